// File: rtl/io_pkg.sv
// rtl/io_pkg.sv - shared types and helpers for board pin conditioning blocks
package io_pkg;

    typedef enum logic [1:0] {
        IDLE,
        PRESS_WAIT,
        PRESSED,
        RELEASE_WAIT
    } btn_state_e;

    // Debounce windows need at least one cycle, so a zero product is clamped to 1.
    function automatic int unsigned ms_to_cycles(input int unsigned freq_hz, input int unsigned ms);
        int unsigned cycles;
        cycles = freq_hz / 1000 * ms;
        return (cycles == 0) ? 1 : cycles;
    endfunction

endpackage

// File: rtl/sync_bit.sv
// rtl/sync_bit.sv - multi-flop synchroniser for one asynchronous input bit
module sync_bit #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter logic        RESET_VAL   = 1'b0
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic d_i,
    output logic q_o
);

    logic [SYNC_STAGES-1:0] sync_q;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            sync_q <= {SYNC_STAGES{RESET_VAL}};
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], d_i};
        end
    end

    assign q_o = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/button_debounce.sv
// rtl/button_debounce.sv - push-button synchroniser, debouncer and press/release/long-press strobes
module button_debounce
    import io_pkg::*;
#(
    parameter int unsigned CLOCK_FREQ_HZ = 50_000_000,
    parameter int unsigned DEBOUNCE_MS   = 20,
    parameter int unsigned LONGPRESS_MS  = 1000,
    parameter bit          ACTIVE_LOW    = 1'b1,
    parameter int unsigned SYNC_STAGES   = 2
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic btn_i,
    output logic level_o,
    output logic press_o,
    output logic release_o,
    output logic long_o
);

    localparam int unsigned DebCycles  = ms_to_cycles(CLOCK_FREQ_HZ, DEBOUNCE_MS);
    localparam int unsigned LongCycles = CLOCK_FREQ_HZ / 1000 * LONGPRESS_MS;
    localparam int unsigned MaxCycles  = (DebCycles > LongCycles) ? DebCycles : LongCycles;
    localparam int          CW         = $clog2(MaxCycles + 1);
    localparam bit          LongEn     = (LONGPRESS_MS != 0) && (LongCycles != 0);

    localparam logic [CW-1:0] DebLast  = CW'(DebCycles - 1);
    localparam logic [CW-1:0] LongLast = CW'(LongCycles - 1);
    localparam logic [CW-1:0] CntOne   = CW'(1);

    logic btn_s;
    logic act;

    // Reset loads the idle pin level so leaving reset never looks like a press.
    sync_bit #(
        .SYNC_STAGES(SYNC_STAGES),
        .RESET_VAL  (ACTIVE_LOW)
    ) u_sync (
        .clk_i (clk_i),
        .rst_ni(rst_ni),
        .d_i   (btn_i),
        .q_o   (btn_s)
    );

    assign act = btn_s ^ ACTIVE_LOW;

    btn_state_e    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [CW-1:0] hold_q, hold_d;
    logic          fired_q, fired_d;
    logic          level_q, level_d;
    logic          press_q, press_d;
    logic          release_q, release_d;
    logic          long_q, long_d;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            hold_q    <= '0;
            fired_q   <= 1'b0;
            level_q   <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
            long_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            hold_q    <= hold_d;
            fired_q   <= fired_d;
            level_q   <= level_d;
            press_q   <= press_d;
            release_q <= release_d;
            long_q    <= long_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        hold_d    = hold_q;
        fired_d   = fired_q;
        // level stays high through the release strobe cycle and drops right after it
        level_d   = release_q ? 1'b0 : level_q;
        press_d   = 1'b0;
        release_d = 1'b0;
        long_d    = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (act) begin
                    state_d = PRESS_WAIT;
                    cnt_d   = '0;
                end
            end
            PRESS_WAIT: begin
                if (!act) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == DebLast) begin
                    state_d = PRESSED;
                    level_d = 1'b1;
                    press_d = 1'b1;
                    hold_d  = '0;
                end else begin
                    cnt_d = cnt_q + CntOne;
                end
            end
            PRESSED: begin
                if (!act) begin
                    state_d = RELEASE_WAIT;
                    cnt_d   = '0;
                end else if (LongEn && !fired_q && hold_q == LongLast) begin
                    long_d  = 1'b1;
                    fired_d = 1'b1;
                end else if (LongEn && !fired_q) begin
                    hold_d = hold_q + CntOne;
                end
            end
            RELEASE_WAIT: begin
                // A bounce back to active only pauses the hold timer.
                if (act) begin
                    state_d = PRESSED;
                    cnt_d   = '0;
                end else if (cnt_q == DebLast) begin
                    state_d   = IDLE;
                    release_d = 1'b1;
                    fired_d   = 1'b0;
                end else begin
                    cnt_d = cnt_q + CntOne;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign level_o   = level_q;
    assign press_o   = press_q;
    assign release_o = release_q;
    assign long_o    = long_q;

endmodule
